modbus_frame_rx: RTL and testbench

MODBUS_FRAME_RX -- requirements
Module: modbus_frame_rx

---
 rtl/modbus_frame_rx_pkg.sv | 26 ++
 rtl/modbus_frame_rx_if.sv | 27 ++
 rtl/modbus_frame_rx_crc.sv | 52 +++++
 rtl/modbus_frame_rx.sv | 168 ++++++++++++++++
 tb/tb_modbus_frame_rx.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/modbus_frame_rx_pkg.sv
// Shared definitions for the Modbus RTU frame receiver: state encoding,
// CRC-16/MODBUS constants and the 3.5-character silence timeout.
package modbus_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RECV  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    // Silence timeout in clocks; above 19200 baud Modbus fixes it at 1.75 ms.
    function automatic int unsigned t35_clocks(input longint unsigned clk_freq,
                                               input longint unsigned baud);
        longint unsigned t;
        if (baud <= 64'd19200)
            t = (clk_freq * 64'd385) / (baud * 64'd10);
        else
            t = (clk_freq * 64'd1750) / 64'd1000000;
        return 32'(t);
    endfunction

endpackage

// File: rtl/modbus_frame_rx_if.sv
// Byte-stream, buffer-read and frame-status signals of the Modbus frame
// receiver; the bench drives through master, the receiver sits on slave.
interface modbus_frame_rx_if;

    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] dev_addr;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_done;
    logic [8:0] frame_len;
    logic       crc_ok;
    logic       addr_ok;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rx_data, rx_done, dev_addr, rd_addr,
        input  rd_data, frame_done, frame_len, crc_ok, addr_ok, frame_err, rx_busy
    );

    modport slave (
        input  rx_data, rx_done, dev_addr, rd_addr,
        output rd_data, frame_done, frame_len, crc_ok, addr_ok, frame_err, rx_busy
    );

endinterface

// File: rtl/modbus_frame_rx_crc.sv
// Bit-serial CRC-16/MODBUS engine: one bit per clock, LSB first.
// reset is asynchronous and active-low, matching the rest of the receiver.
module crc16_modbus
    import modbus_frame_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        busy,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [7:0]  sh_q;
    logic [3:0]  bits_q;

    // Next CRC value for the bit currently at the bottom of the shift register.
    always_comb begin
        crc_d = crc_q >> 1;
        if (crc_q[0] ^ sh_q[0])
            crc_d = crc_d ^ CRC_POLY;
    end

    // Load a byte on byte_valid, then shift it through the CRC over eight clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q  <= CRC_INIT;
            sh_q   <= '0;
            bits_q <= '0;
        end else begin
            if (byte_valid) begin
                sh_q   <= byte_in;
                bits_q <= 4'd8;
            end else if (bits_q != 4'd0) begin
                sh_q   <= sh_q >> 1;
                bits_q <= bits_q - 4'd1;
            end

            if (init)
                crc_q <= CRC_INIT;
            else if (bits_q != 4'd0)
                crc_q <= crc_d;
        end
    end

    assign busy    = (bits_q != 4'd0);
    assign crc_out = crc_q;

endmodule

// File: rtl/modbus_frame_rx.sv
// Modbus RTU frame receiver: delimits frames by 3.5-character silence,
// buffers the bytes, and reports length, CRC, address and error status.
module modbus_frame_rx
    import modbus_frame_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned MAX_LEN   = 256
) (
    input logic              clk_in,
    input logic              rst_n_in,
    modbus_frame_rx_if.slave bus
);

    localparam int unsigned   T35      = t35_clocks(64'(CLK_FREQ), 64'(BAUD_RATE));
    localparam int unsigned   SW       = $clog2(T35 + 16);
    localparam logic [SW-1:0] SIL_TERM = SW'(T35 - 1);
    localparam int unsigned   AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t        state_q;
    logic [SW-1:0] sil_q;
    logic [8:0]    cnt_q;
    logic          ovf_q;
    logic [7:0]    first_q;
    logic          frame_done_q;
    logic [8:0]    frame_len_q;
    logic          crc_ok_q;
    logic          addr_ok_q;
    logic          frame_err_q;
    logic          rx_busy_q;
    logic [7:0]    rd_data_q;

    logic [7:0]    mem [MAX_LEN];
    logic          we_d;
    logic [AW-1:0] waddr_d;
    logic          crc_init_d;
    logic          crc_busy;
    logic [15:0]   crc_val;
    logic          short_d;
    logic          bad_d;

    // Buffer write and CRC feed: only bytes that land in the buffer enter the CRC.
    always_comb begin
        we_d       = 1'b0;
        waddr_d    = '0;
        crc_init_d = 1'b0;
        if (bus.rx_done) begin
            if (state_q == ST_IDLE) begin
                we_d       = 1'b1;
                crc_init_d = 1'b1;
            end else if (state_q == ST_RECV && 32'(cnt_q) < MAX_LEN) begin
                we_d    = 1'b1;
                waddr_d = AW'(cnt_q);
            end
        end
    end

    // Frame verdict inputs evaluated in CHECK.
    always_comb begin
        short_d = (cnt_q < 9'd4);
        bad_d   = short_d || ovf_q;
    end

    crc16_modbus u_crc (
        .clk        (clk_in),
        .reset      (rst_n_in),
        .init       (crc_init_d),
        .byte_in    (bus.rx_data),
        .byte_valid (we_d),
        .busy       (crc_busy),
        .crc_out    (crc_val)
    );

    // Frame buffer storage; no reset so it maps onto block RAM.
    always_ff @(posedge clk_in) begin
        if (we_d)
            mem[waddr_d] <= bus.rx_data;
    end

    // Registered buffer read port, available in every state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            rd_data_q <= '0;
        else if (32'(bus.rd_addr) < MAX_LEN)
            rd_data_q <= mem[AW'(bus.rd_addr)];
        else
            rd_data_q <= '0;
    end

    // Frame delimiting FSM with registered status outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_INIT;
            sil_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            first_q      <= '0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            crc_ok_q     <= 1'b0;
            addr_ok_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (bus.rx_done) begin
                        sil_q <= '0;
                    end else if (sil_q >= SIL_TERM) begin
                        sil_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        sil_q <= sil_q + SW'(1);
                    end
                end
                ST_IDLE: begin
                    sil_q <= '0;
                    if (bus.rx_done) begin
                        state_q   <= ST_RECV;
                        rx_busy_q <= 1'b1;
                        cnt_q     <= 9'd1;
                        ovf_q     <= 1'b0;
                        first_q   <= bus.rx_data;
                    end
                end
                ST_RECV: begin
                    // A byte on the terminal count cycle takes priority over the timeout.
                    if (bus.rx_done) begin
                        sil_q <= '0;
                        if (32'(cnt_q) >= MAX_LEN)
                            ovf_q <= 1'b1;
                        if (cnt_q != 9'd511)
                            cnt_q <= cnt_q + 9'd1;
                    end else if (sil_q >= SIL_TERM && !crc_busy) begin
                        sil_q   <= '0;
                        state_q <= ST_CHECK;
                    end else begin
                        sil_q <= sil_q + SW'(1);
                    end
                end
                ST_CHECK: begin
                    frame_len_q  <= cnt_q;
                    frame_err_q  <= bad_d;
                    crc_ok_q     <= !bad_d && (crc_val == 16'h0000);
                    addr_ok_q    <= (first_q == bus.dev_addr) || (first_q == 8'h00);
                    frame_done_q <= 1'b1;
                    rx_busy_q    <= 1'b0;
                    sil_q        <= '0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_INIT;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_len  = frame_len_q;
    assign bus.crc_ok     = crc_ok_q;
    assign bus.addr_ok    = addr_ok_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_modbus_frame_rx.sv
// Directed bench for modbus_frame_rx: reset values, valid/bad/broadcast
// frames, short and overflowing frames, byte on the timeout boundary,
// and reset in the middle of a frame.
module tb_modbus_frame_rx;

    // 50000 * 385 / (9600 * 10) = 200.52 -> 200 clocks of silence
    localparam int T35 = 200;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   fd_total = 0;

    modbus_frame_rx_if bus ();

    modbus_frame_rx #(
        .CLK_FREQ  (50000),
        .BAUD_RATE (9600),
        .MAX_LEN   (256)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running count of frame_done pulses
    always @(posedge clk) begin
        if (bus.frame_done === 1'b1)
            fd_total <= fd_total + 1;
    end

    // Hard time limit
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        pulse(b);
        idle(9);
    endtask

    task automatic send8(input logic [63:0] f);
        for (int i = 7; i >= 0; i--)
            send_byte(f[i*8 +: 8]);
    endtask

    task automatic wait_frame(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (bus.frame_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_buf(input logic [7:0] a, output logic [7:0] d);
        bus.rd_addr = a;
        idle(1);
        d = bus.rd_data;
    endtask

    initial begin
        logic       got;
        logic [7:0] d;
        int         fd0;

        rst_n        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_done  = 1'b0;
        bus.dev_addr = 8'h01;
        bus.rd_addr  = 8'h00;
        idle(3);

        // Reset values
        check("rst_rd_data",    32'(bus.rd_data),    32'h0);
        check("rst_frame_done", 32'(bus.frame_done), 32'h0);
        check("rst_frame_len",  32'(bus.frame_len),  32'h0);
        check("rst_crc_ok",     32'(bus.crc_ok),     32'h0);
        check("rst_addr_ok",    32'(bus.addr_ok),    32'h0);
        check("rst_frame_err",  32'(bus.frame_err),  32'h0);
        check("rst_rx_busy",    32'(bus.rx_busy),    32'h0);

        rst_n = 1'b1;
        idle(20);

        // Frame arriving before the first silence period is discarded
        fd0 = fd_total;
        send8(64'h0103_0000_000A_C5CD);
        idle(T35 + 20);
        check("init_discard_fd",   32'(fd_total - fd0), 32'h0);
        check("init_discard_busy", 32'(bus.rx_busy),    32'h0);

        // Valid frame
        fd0 = fd_total;
        send8(64'h0103_0000_000A_C5CD);
        check("valid_busy", 32'(bus.rx_busy), 32'h1);
        wait_frame(T35 + 30, got);
        check("valid_fd_seen", 32'(got),           32'h1);
        check("valid_len",     32'(bus.frame_len), 32'h8);
        check("valid_crc_ok",  32'(bus.crc_ok),    32'h1);
        check("valid_addr_ok", 32'(bus.addr_ok),   32'h1);
        check("valid_err",     32'(bus.frame_err), 32'h0);
        read_buf(8'd6, d);
        check("valid_buf6", 32'(d), 32'hC5);
        read_buf(8'd0, d);
        check("valid_buf0", 32'(d), 32'h01);
        read_buf(8'd7, d);
        check("valid_buf7", 32'(d), 32'hCD);
        idle(10);
        check("valid_fd_count", 32'(fd_total - fd0), 32'h1);
        check("valid_len_hold", 32'(bus.frame_len),  32'h8);

        // Corrupted CRC, address mismatch
        bus.dev_addr = 8'h05;
        send8(64'h0103_0000_000A_C5CE);
        wait_frame(T35 + 30, got);
        check("badcrc_fd_seen", 32'(got),           32'h1);
        check("badcrc_len",     32'(bus.frame_len), 32'h8);
        check("badcrc_crc_ok",  32'(bus.crc_ok),    32'h0);
        check("badcrc_err",     32'(bus.frame_err), 32'h0);
        check("badcrc_addr_ok", 32'(bus.addr_ok),   32'h0);

        // Broadcast address accepted regardless of dev_addr
        send8(64'h0003_0000_000A_C5CD);
        wait_frame(T35 + 30, got);
        check("bcast_fd_seen", 32'(got),          32'h1);
        check("bcast_addr_ok", 32'(bus.addr_ok),  32'h1);
        check("bcast_crc_ok",  32'(bus.crc_ok),   32'h0);
        bus.dev_addr = 8'h01;

        // Short frame
        send_byte(8'h01);
        send_byte(8'h03);
        wait_frame(T35 + 30, got);
        check("short_fd_seen", 32'(got),           32'h1);
        check("short_err",     32'(bus.frame_err), 32'h1);
        check("short_len",     32'(bus.frame_len), 32'h2);
        check("short_crc_ok",  32'(bus.crc_ok),    32'h0);

        // 260-byte frame overflows the 256-byte buffer
        for (int i = 0; i < 260; i++)
            send_byte((i < 256) ? 8'(i) : 8'hEE);
        wait_frame(T35 + 30, got);
        check("ovf_fd_seen", 32'(got),           32'h1);
        check("ovf_err",     32'(bus.frame_err), 32'h1);
        check("ovf_len",     32'(bus.frame_len), 32'h104);
        check("ovf_crc_ok",  32'(bus.crc_ok),    32'h0);
        read_buf(8'd255, d);
        check("ovf_buf255", 32'(d), 32'hFF);
        read_buf(8'd0, d);
        check("ovf_buf0", 32'(d), 32'h00);
        read_buf(8'd1, d);
        check("ovf_buf1", 32'(d), 32'h01);
        read_buf(8'd3, d);
        check("ovf_buf3", 32'(d), 32'h03);

        // Fifth byte lands exactly on the T35-1 count: one 9-byte frame
        fd0 = fd_total;
        for (int i = 0; i < 9; i++) begin
            pulse(8'(8'h11 * (i + 1)));
            if (i == 4) begin
                check("edge_busy", 32'(bus.rx_busy),    32'h1);
                check("edge_no_fd", 32'(fd_total - fd0), 32'h0);
            end
            idle((i == 3) ? T35 - 1 : 9);
        end
        wait_frame(T35 + 30, got);
        check("edge_fd_seen", 32'(got),           32'h1);
        check("edge_len",     32'(bus.frame_len), 32'h9);
        check("edge_err",     32'(bus.frame_err), 32'h0);
        read_buf(8'd4, d);
        check("edge_buf4", 32'(d), 32'h55);
        idle(T35 + 10);
        check("edge_fd_count", 32'(fd_total - fd0), 32'h1);

        // Reset after three bytes drops the partial frame
        fd0 = fd_total;
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h00);
        rst_n = 1'b0;
        idle(2);
        check("midrst_busy", 32'(bus.rx_busy),    32'h0);
        check("midrst_len",  32'(bus.frame_len),  32'h0);
        check("midrst_fd",   32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;
        idle(T35 + 30);
        check("midrst_fd_count", 32'(fd_total - fd0), 32'h0);

        // After the silence period a valid frame is received again
        send8(64'h0103_0000_000A_C5CD);
        wait_frame(T35 + 30, got);
        check("post_fd_seen", 32'(got),           32'h1);
        check("post_crc_ok",  32'(bus.crc_ok),    32'h1);
        check("post_len",     32'(bus.frame_len), 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
